// File: rtl/serial_tx_engine_pkg.sv
// Shared types and helpers for the serial transmit path.
package serial_pkg;

  localparam int WORD_W        = 9;
  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
  } tx_state_t;

  // Frame width is always 5..9 data bits regardless of what software wrote.
  function automatic logic [3:0] clamp_bits(input logic [3:0] n);
    if (n < 4'(DATA_BITS_MIN)) return 4'(DATA_BITS_MIN);
    if (n > 4'(DATA_BITS_MAX)) return 4'(DATA_BITS_MAX);
    return n;
  endfunction

  // Parity over the first n data bits; odd mode inverts the even result.
  function automatic logic calc_parity(input logic [WORD_W-1:0] d,
                                       input logic [3:0] n,
                                       input logic [1:0] mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < WORD_W; i++)
      if (i < int'(n)) p = p ^ d[i];
    return p ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/serial_tx_engine_if.sv
// Read port of the TX FIFO as seen by the transmit engine.
interface serial_tx_engine_if;
  import serial_pkg::*;

  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_rd_data;
  logic              fifo_rd_req;

  modport master (input fifo_empty, input fifo_rd_data, output fifo_rd_req);
  modport slave  (output fifo_empty, output fifo_rd_data, input fifo_rd_req);
endinterface

// File: rtl/serial_tx_engine_baud_tick_gen.sv
// Fractional bit-period timer. Each restart loads a period of int + carry,
// where carry is the overflow of a wrapping fractional accumulator.
// bit_end marks the last cycle of the loaded period.
module baud_tick_gen #(
  parameter int DIV_INT_W  = 16,
  parameter int DIV_FRAC_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  restart,
  input  logic [DIV_INT_W-1:0]  div_int,
  input  logic [DIV_FRAC_W-1:0] div_frac,
  output logic                  bit_end
);

  logic [DIV_INT_W:0]    cnt;
  logic [DIV_FRAC_W-1:0] acc;
  logic                  running;
  logic [DIV_INT_W-1:0]  int_eff;
  logic [DIV_FRAC_W:0]   sum;
  logic [DIV_INT_W:0]    period;

  // Next period length: divisor floored at 2, plus fractional carry.
  always_comb begin
    int_eff = (div_int < DIV_INT_W'(2)) ? DIV_INT_W'(2) : div_int;
    sum     = {1'b0, acc} + {1'b0, div_frac};
    period  = {1'b0, int_eff} + {{DIV_INT_W{1'b0}}, sum[DIV_FRAC_W]};
  end

  assign bit_end = running && (cnt == '0);

  // Down-counter reloaded on restart; stops after bit_end without restart.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt     <= '0;
      acc     <= '0;
      running <= 1'b0;
    end else if (restart) begin
      cnt     <= period - (DIV_INT_W+1)'(1);
      acc     <= sum[DIV_FRAC_W-1:0];
      running <= 1'b1;
    end else if (running) begin
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - (DIV_INT_W+1)'(1);
    end
  end

endmodule

// File: rtl/serial_tx_engine.sv
// UART transmit engine: pops a FIFO word per frame and serializes it
// LSB-first with start, 5..9 data, optional parity and 1/2 stop bits.
module serial_tx_engine
  import serial_pkg::*;
#(
  parameter int DIV_INT_W  = 16,
  parameter int DIV_FRAC_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DIV_INT_W-1:0]  baud_div_int,
  input  logic [DIV_FRAC_W-1:0] baud_div_frac,
  input  logic [3:0]            data_bits,
  input  logic [1:0]            parity_mode,
  input  logic                  two_stop,
  input  logic                  break_request,
  serial_tx_engine_if.master    fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  tx_state_t             state, state_nx;
  logic [WORD_W-1:0]     shreg;
  logic [3:0]            nbits, bit_cnt;
  logic                  par_en, par_bit, two_stop_r, stop_cnt;
  logic [DIV_INT_W-1:0]  div_int_r, div_int_sel;
  logic [DIV_FRAC_W-1:0] div_frac_r, div_frac_sel;
  logic                  bit_end, restart, last_data, last_stop;

  // The first bit period is armed during LOAD, before the divisor regs
  // have captured the new config, so LOAD feeds the live inputs through.
  assign div_int_sel  = (state == ST_LOAD) ? baud_div_int  : div_int_r;
  assign div_frac_sel = (state == ST_LOAD) ? baud_div_frac : div_frac_r;
  assign last_data    = (bit_cnt == nbits - 4'd1);
  assign last_stop    = !two_stop_r || stop_cnt;

  baud_tick_gen #(.DIV_INT_W(DIV_INT_W), .DIV_FRAC_W(DIV_FRAC_W)) u_baud (
    .clock    (clock),
    .reset    (reset),
    .restart  (restart),
    .div_int  (div_int_sel),
    .div_frac (div_frac_sel),
    .bit_end  (bit_end)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (break_request)                    state_nx = ST_BREAK;
                 else if (enable && !fifo.fifo_empty)  state_nx = ST_LOAD;
      ST_LOAD:   state_nx = ST_START;
      ST_START:  if (bit_end) state_nx = ST_DATA;
      ST_DATA:   if (bit_end && last_data) state_nx = par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_nx = ST_STOP;
      ST_STOP:   if (bit_end && last_stop) state_nx = ST_IDLE;
      ST_BREAK:  if (!break_request) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Outputs: line level, pop pulse, status, and timer re-arm at bit starts.
  always_comb begin
    tx               = 1'b1;
    fifo.fifo_rd_req = (state == ST_LOAD);
    busy             = (state != ST_IDLE) && (state != ST_BREAK);
    frame_done       = (state == ST_STOP) && bit_end && last_stop;
    restart          = (state == ST_LOAD) || (bit_end && !frame_done);
    case (state)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shreg[0];
      ST_PARITY: tx = par_bit;
      ST_BREAK:  tx = 1'b0;
      default:   tx = 1'b1;
    endcase
  end

  // Frame registers: captured at LOAD, then walked by bit_end.
  always_ff @(posedge clock) begin
    if (!reset) begin
      shreg      <= '0;
      nbits      <= 4'(DATA_BITS_MIN);
      bit_cnt    <= '0;
      par_en     <= 1'b0;
      par_bit    <= 1'b0;
      two_stop_r <= 1'b0;
      stop_cnt   <= 1'b0;
      div_int_r  <= '0;
      div_frac_r <= '0;
    end else if (state == ST_LOAD) begin
      shreg      <= fifo.fifo_rd_data;
      nbits      <= clamp_bits(data_bits);
      bit_cnt    <= '0;
      par_en     <= (parity_mode == PARITY_EVEN) || (parity_mode == PARITY_ODD);
      par_bit    <= calc_parity(fifo.fifo_rd_data, clamp_bits(data_bits), parity_mode);
      two_stop_r <= two_stop;
      stop_cnt   <= 1'b0;
      div_int_r  <= baud_div_int;
      div_frac_r <= baud_div_frac;
    end else if (bit_end) begin
      if (state == ST_DATA) begin
        shreg   <= {1'b0, shreg[WORD_W-1:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (state == ST_STOP) stop_cnt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_tx_engine.sv
// Bench for serial_tx_engine: FIFO model with lagged flags, line monitor
// capturing each frame, and a scoreboard of expected line waveforms.
module tb_serial_tx_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] baud_div_int = 16'd4;
  logic [7:0]  baud_div_frac = 8'd0;
  logic [3:0]  data_bits = 4'd8;
  logic [1:0]  parity_mode = 2'd0;
  logic        two_stop = 1'b0;
  logic        break_request = 1'b0;
  logic        tx, busy, frame_done;

  serial_tx_engine_if ff ();

  serial_tx_engine dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .baud_div_int  (baud_div_int),
    .baud_div_frac (baud_div_frac),
    .data_bits     (data_bits),
    .parity_mode   (parity_mode),
    .two_stop      (two_stop),
    .break_request (break_request),
    .fifo          (ff),
    .tx            (tx),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [255:0] wave;
    int           len;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] fq[$];
  int total = 0, bad = 0;
  int pops = 0, bad_pops = 0, pushes = 0, exp_frames = 0;
  int frames_done = 0, last_len = 0, acc_m = 0;
  bit gap_chk_en = 0;
  bit cap_on = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line waveform for one frame, one entry per clock cycle.
  function automatic void build(input logic [8:0] w, output exp_t e);
    int nb, ones, bl[$], s, p;
    nb = (data_bits < 5) ? 5 : (data_bits > 9) ? 9 : int'(data_bits);
    bl.push_back(0);
    ones = 0;
    for (int i = 0; i < nb; i++) begin
      bl.push_back(int'(w[i]));
      ones += int'(w[i]);
    end
    if (parity_mode == 2'd1) bl.push_back(ones % 2);
    if (parity_mode == 2'd2) bl.push_back(1 - (ones % 2));
    bl.push_back(1);
    if (two_stop) bl.push_back(1);
    e.wave = '0;
    e.len  = 0;
    foreach (bl[k]) begin
      s     = acc_m + int'(baud_div_frac);
      acc_m = s % 256;
      p     = ((baud_div_int < 2) ? 2 : int'(baud_div_int)) + ((s >= 256) ? 1 : 0);
      for (int c = 0; c < p; c++) begin
        e.wave[e.len] = bl[k][0];
        e.len++;
      end
    end
  endfunction

  task automatic push(input logic [8:0] w);
    exp_t e;
    build(w, e);
    sb.push_back(e);
    fq.push_back(w);
    pushes++;
    exp_frames++;
  endtask

  task automatic cfg(input int di, input int df, input int nb, input int pm, input int ts);
    baud_div_int  = 16'(di);
    baud_div_frac = 8'(df);
    data_bits     = 4'(nb);
    parity_mode   = 2'(pm);
    two_stop      = ts[0];
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (frames_done < target) chk("timeout_frame", 0, 1);
  endtask

  task automatic wait_capture();
    int n;
    n = 0;
    while (!cap_on && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!cap_on) chk("timeout_start", 0, 1);
  endtask

  // FIFO model: pop on rd_req, head data one cycle later, empty two cycles later.
  initial begin
    logic empty_d1;
    empty_d1 = 1'b1;
    ff.fifo_empty   <= 1'b1;
    ff.fifo_rd_data <= '0;
    forever begin
      @(posedge clock);
      if (ff.fifo_rd_req === 1'b1) begin
        if (fq.size() > 0) begin
          void'(fq.pop_front());
          pops++;
        end else bad_pops++;
      end
      ff.fifo_empty   <= empty_d1;
      empty_d1         = (fq.size() == 0);
      ff.fifo_rd_data <= (fq.size() > 0) ? fq[0] : 9'd0;
    end
  end

  // Line monitor: capture from the start bit through frame_done.
  initial begin
    logic [255:0] cap;
    int idx, gap;
    bit gap_valid;
    exp_t e;
    cap = '0; idx = 0; gap = 0; gap_valid = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        cap_on    = 0;
        gap_valid = 0;
      end else begin
        if (!cap_on && busy && !tx) begin
          cap_on = 1;
          idx    = 0;
          cap    = '0;
          if (gap_chk_en && gap_valid) chk("idle_gap", gap, 2);
          gap_valid = 0;
        end
        if (cap_on) begin
          if (idx < 256) cap[idx] = tx;
          idx++;
          if (frame_done) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
              e = sb.pop_front();
              chk("frame_len", idx, e.len);
              chk("frame_wave", cap, e.wave);
            end
            cap_on    = 0;
            last_len  = idx;
            frames_done++;
            gap       = 0;
            gap_valid = 1;
          end
        end else begin
          if (frame_done) chk("stray_done", 1, 0);
          gap++;
        end
      end
    end
  end

  initial begin
    int p0;
    repeat (3) @(negedge clock);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_req", ff.fifo_rd_req, 0);
    chk("rst_done", frame_done, 0);
    reset  = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge clock);
    chk("idle_empty_tx", tx, 1);
    chk("idle_empty_busy", busy, 0);

    // 8N1 at 4 clocks/bit
    cfg(4, 0, 8, 0, 0);
    p0 = pops;
    push(9'h0A5);
    wait_frames(1);
    chk("t1_len", last_len, 40);
    chk("t1_pops", pops - p0, 1);

    // 9 bits, even parity
    cfg(4, 0, 9, 1, 0);
    push(9'h1FF);
    wait_frames(2);
    chk("t2_len", last_len, 48);

    // 7 bits, odd parity, two stop bits
    cfg(4, 0, 7, 2, 1);
    push(9'h055);
    wait_frames(3);
    chk("t3_len", last_len, 44);

    // fractional divisor 3.5
    cfg(3, 128, 8, 0, 0);
    push(9'h03C);
    wait_frames(4);
    chk("t4_len", last_len, 35);

    // clamps: divisor 1 -> 2, 3 bits -> 5, mode 3 -> none
    cfg(1, 0, 3, 3, 0);
    push(9'h1F3);
    wait_frames(5);
    chk("clamp_lo_len", last_len, 14);
    // 15 bits -> 9, even parity
    cfg(2, 0, 15, 1, 0);
    push(9'h0F0);
    wait_frames(6);
    chk("clamp_hi_len", last_len, 24);

    // three queued words back to back through the lagged FIFO
    cfg(4, 0, 8, 2, 0);
    p0 = pops;
    push(9'h012);
    push(9'h1C3);
    push(9'h0FF);
    wait_frames(7);
    gap_chk_en = 1;
    wait_frames(9);
    gap_chk_en = 0;
    repeat (30) @(negedge clock);
    chk("t5_pops", pops - p0, 3);
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_tx", tx, 1);

    // config change and enable drop mid-frame
    cfg(4, 0, 8, 0, 0);
    push(9'h0C3);
    push(9'h13C);
    wait_capture();
    data_bits   = 4'd5;
    parity_mode = 2'd1;
    enable      = 1'b0;
    wait_frames(10);
    repeat (40) @(negedge clock);
    chk("hold_busy", busy, 0);
    chk("hold_fifo", fq.size(), 1);
    data_bits   = 4'd8;
    parity_mode = 2'd0;
    enable      = 1'b1;
    wait_frames(11);

    // reset during data bit 3
    push(9'h0A5);
    wait_capture();
    repeat (18) @(negedge clock);
    chk("t6_busy_pre", busy, 1);
    reset = 1'b0;
    @(negedge clock);
    chk("t6_rst_tx", tx, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", frame_done, 0);
    chk("t6_rst_req", ff.fifo_rd_req, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    void'(sb.pop_front());
    exp_frames--;
    acc_m = 0;
    repeat (30) @(negedge clock);
    chk("t6_no_reread", busy, 0);

    // break in IDLE
    break_request = 1'b1;
    @(negedge clock);
    chk("brk_tx", tx, 0);
    repeat (5) @(negedge clock);
    chk("brk_hold_tx", tx, 0);
    chk("brk_busy", busy, 0);
    break_request = 1'b0;
    @(negedge clock);
    chk("brk_release_tx", tx, 1);
    push(9'h05A);
    wait_frames(12);

    repeat (10) @(negedge clock);
    chk("sb_left", sb.size(), 0);
    chk("pops_total", pops, pushes);
    chk("empty_pops", bad_pops, 0);
    chk("frames_total", frames_done, exp_frames);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
